serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes DIFF = A - B - Bin one bit per clock, LSB first, using a registered borrow chain. It is the inverse-operation companion to the ripple full-adder datapath.
- Used where area beats speed, e.g. decrementing LCD cursor/address counters and computing column offsets.
- Start/busy/done handshake. Result and flags are held until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- CNT_W, 4, width of the bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request: latch operands and begin; honoured only in IDLE.
- A  input  WIDTH  minuend, sampled on the accepted start cycle.
- B  input  WIDTH  subtrahend, sampled on the accepted start cycle.
- Bin  input  1  borrow-in, sampled on the accepted start cycle.
- DIFF  output  WIDTH  result A-B-Bin mod 2^WIDTH.
- Bout  output  1  borrow-out; 1 when A < B+Bin (unsigned).
- Ovf  output  1  signed overflow: A[msb] != B[msb] and DIFF[msb] != A[msb].
- Zero  output  1  DIFF == 0.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; DIFF=0, Bout=0, Ovf=0, Zero=0, busy=0, done=0; internal shift registers, borrow and counter cleared. Reset wins over every other input and aborts any operation in progress with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE, start=1: latch A, B into shift registers. Borrow register <= Bin. Counter <= 0. busy <= 1. Go to RUN. With start=0, remain in IDLE.
- RUN, each cycle, using a = A_sh[0], b = B_sh[0], c = borrow:
  - d = a^b^c
  - borrow <= (~a&b) | (~(a^b)&c)
  - shift d into the result register MSB-first from the top (right shift), so after WIDTH shifts bit 0 is at position 0
  - shift A_sh and B_sh right; counter++
  - on the cycle processing bit WIDTH-1, also capture a_msb/b_msb for Ovf; go to FIN when counter == WIDTH-1.
- FIN (single cycle): DIFF <= result register; Bout <= borrow; Zero <= (result == 0); Ovf computed from the captured MSBs and the result MSB. done <= 1 and busy <= 0 on this transition. Return to IDLE.
- Timing: start sampled at edge 0. busy is high from edge 0 through edge WIDTH, i.e. for WIDTH cycles of RUN. done is high for exactly one cycle after edge WIDTH+1. Latency from start to done = WIDTH+1 clocks.
- DIFF and flags change only at the FIN edge or at reset; they are stable between operations, including during a subsequent RUN.
- start while busy or in FIN: ignored, no queuing, and operand inputs are not resampled.
- start held high continuously: a new operation is accepted on the first IDLE cycle after done, so back-to-back throughput is one result per WIDTH+2 clocks.
- A, B and Bin may change freely after the accepted start cycle without affecting the result.
- Wrap-around: result is modulo 2^WIDTH; Bout reports the unsigned underflow.

Test Plan:
- WIDTH=8: A=0x35, B=0x12, Bin=0, start pulse -> done exactly 9 clocks later; DIFF=0x23, Bout=0, Ovf=0, Zero=0; busy high for 8 cycles.
- A=0x12, B=0x35, Bin=0 -> DIFF=0xDD, Bout=1, Ovf=0, Zero=0.
- A=0x00, B=0x00, Bin=1 -> DIFF=0xFF, Bout=1; then A=0x5A, B=0x5A, Bin=0 -> DIFF=0x00, Zero=1, Bout=0.
- A=0x80, B=0x01 -> DIFF=0x7F, Ovf=1, Bout=0; A=0x7F, B=0xFF -> DIFF=0x80, Ovf=1, Bout=1.
- Start A=0x35, B=0x12; pulse start with A=0xFF, B=0x00 at cycle 3 and change the A/B inputs mid-run -> single done, DIFF=0x23, second start ignored; previous DIFF held during RUN.
- Start an operation and assert rst at cycle 4 -> next cycle all outputs 0, state IDLE, no done pulse; a fresh start afterwards gives a correct result. Also run a random sweep against a reference model (A-B-Bin), WIDTH=8 and WIDTH=5.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start request,
// operands and borrow-in toward the datapath, result and flags back.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic [WIDTH-1:0] DIFF;
   logic             Bout;
   logic             Ovf;
   logic             Zero;
   logic             busy;
   logic             done;

   modport master (
      output start, A, B, Bin,
      input  DIFF, Bout, Ovf, Zero, busy, done
   );

   modport slave (
      input  start, A, B, Bin,
      output DIFF, Bout, Ovf, Zero, busy, done
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - Bin, one bit per clock, LSB first,
// with a registered borrow. Result and flags hold until the next accepted start.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one difference bit per clock, WIDTH clocks
// FIN   | publish result and flags, pulse done
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] res_q,    res_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             a_msb_q,  a_msb_d;
   logic             b_msb_q,  b_msb_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic             bout_q,   bout_d;
   logic             ovf_q,    ovf_d;
   logic             zero_q,   zero_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic bit_a, bit_b, bit_d;

   assign bit_a = a_sh_q[0];
   assign bit_b = b_sh_q[0];
   assign bit_d = bit_a ^ bit_b ^ borrow_q;

   // Next-state and datapath: sequencing, one full-subtractor step per RUN cycle
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_sh_d   = bus.A;
               b_sh_d   = bus.B;
               borrow_d = bus.Bin;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            borrow_d = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
            res_d    = {bit_d, res_q[WIDTH-1:1]};
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               // operand MSBs are only visible here, keep them for the overflow flag
               a_msb_d = bit_a;
               b_msb_d = bit_b;
               busy_d  = 1'b0;
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            diff_d  = res_q;
            bout_d  = borrow_q;
            zero_d  = (res_q == '0);
            ovf_d   = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset that aborts any operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.DIFF = diff_q;
   assign bus.Bout = bout_q;
   assign bus.Ovf  = ovf_q;
   assign bus.Zero = zero_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of the bit-serial subtractor at WIDTH=8 and WIDTH=5.
module tb_serial_subtractor;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(5)) bus5 ();

   serial_subtractor #(.WIDTH(8), .CNT_W(4)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_subtractor #(.WIDTH(5), .CNT_W(3)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one start pulse, then wait (bounded) for done; reports latency and busy cycles.
   task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bo, output logic ov,
                         output logic z, output int lat, output int bn);
      logic got, dn, bz;
      @(negedge clk);
      if (w == 8) begin
         bus8.A = a; bus8.B = b; bus8.Bin = bin; bus8.start = 1'b1;
      end else begin
         bus5.A = a[4:0]; bus5.B = b[4:0]; bus5.Bin = bin; bus5.start = 1'b1;
      end
      @(negedge clk);
      bus8.start = 1'b0;
      bus5.start = 1'b0;
      lat = 0; bn = 0; got = 1'b0;
      d = '0; bo = 1'b0; ov = 1'b0; z = 1'b0;
      while (!got && lat < 40) begin
         dn = (w == 8) ? bus8.done : bus5.done;
         bz = (w == 8) ? bus8.busy : bus5.busy;
         if (dn) begin
            got = 1'b1;
            d  = (w == 8) ? bus8.DIFF : {3'b000, bus5.DIFF};
            bo = (w == 8) ? bus8.Bout : bus5.Bout;
            ov = (w == 8) ? bus8.Ovf  : bus5.Ovf;
            z  = (w == 8) ? bus8.Zero : bus5.Zero;
         end else begin
            if (bz) bn++;
            lat++;
            @(negedge clk);
         end
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      dn = (w == 8) ? bus8.done : bus5.done;
      chk("done_one_cycle", 32'(dn), 32'd0);
   endtask

   task automatic do_vec(input string tag, input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] ed, input logic ebo,
                         input logic eov, input logic ez);
      logic [7:0] d;
      logic bo, ov, z;
      int lat, bn;
      run_op(w, a, b, bin, d, bo, ov, z, lat, bn);
      chk({tag, ".diff"}, 32'(d), 32'(ed));
      chk({tag, ".bout"}, 32'(bo), 32'(ebo));
      chk({tag, ".ovf"}, 32'(ov), 32'(eov));
      chk({tag, ".zero"}, 32'(z), 32'(ez));
      chk({tag, ".latency"}, 32'(lat), 32'(w + 1));
      chk({tag, ".busy_cycles"}, 32'(bn), 32'(w));
   endtask

   // Reference: plain integer subtraction, borrow from sign, overflow from operand/result MSBs.
   task automatic rand_vec(input int w);
      logic [7:0] a, b, ed, mask;
      logic bin, ebo, eov;
      int f;
      mask = 8'((1 << w) - 1);
      a   = 8'($urandom_range(0, 255)) & mask;
      b   = 8'($urandom_range(0, 255)) & mask;
      bin = 1'($urandom_range(0, 1));
      f   = int'(a) - int'(b) - int'(bin);
      ed  = 8'(f) & mask;
      ebo = (f < 0);
      eov = (a[w-1] != b[w-1]) && (ed[w-1] != a[w-1]);
      do_vec((w == 8) ? "rnd8" : "rnd5", w, a, b, bin, ed, ebo, eov, (ed == 8'h00));
   endtask

   initial begin
      logic [7:0] prev;
      int n_done, held_bad, stray;
      n_checks = 0;
      n_fail   = 0;
      bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Bin = 1'b0;
      bus5.start = 1'b0; bus5.A = '0; bus5.B = '0; bus5.Bin = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst.diff", 32'(bus8.DIFF), 32'd0);
      chk("rst.flags", {28'd0, bus8.Bout, bus8.Ovf, bus8.Zero, bus8.busy}, 32'd0);
      chk("rst.done", 32'(bus8.done), 32'd0);

      do_vec("v35_12", 8, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0);
      do_vec("v12_35", 8, 8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0, 1'b0);
      do_vec("v00_00_b1", 8, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      do_vec("v5a_5a", 8, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      do_vec("v80_01", 8, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
      do_vec("v7f_ff", 8, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
      do_vec("w5_00_01", 5, 8'h00, 8'h01, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0);
      do_vec("w5_10_01", 5, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0);

      // Start ignored mid-run, operands changed mid-run, previous result held while busy.
      prev = bus8.DIFF;
      @(negedge clk);
      bus8.A = 8'h35; bus8.B = 8'h12; bus8.Bin = 1'b0; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus8.A = 8'hFF; bus8.B = 8'h00; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0; bus8.A = 8'hAA; bus8.B = 8'h55; bus8.Bin = 1'b1;
      n_done = 0; held_bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus8.busy && bus8.DIFF !== prev) held_bad = 1;
         if (bus8.done) n_done++;
         @(negedge clk);
      end
      chk("midrun.held", 32'(held_bad), 32'd0);
      chk("midrun.n_done", 32'(n_done), 32'd1);
      chk("midrun.diff", 32'(bus8.DIFF), 32'h23);
      chk("midrun.bout", 32'(bus8.Bout), 32'd0);

      // Reset during RUN: outputs cleared next cycle, no done, then a clean operation.
      bus8.A = 8'h12; bus8.B = 8'h35; bus8.Bin = 1'b0; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.diff", 32'(bus8.DIFF), 32'd0);
      chk("abort.flags", {28'd0, bus8.Bout, bus8.Ovf, bus8.Zero, bus8.busy}, 32'd0);
      stray = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus8.done || bus8.busy) stray++;
         @(negedge clk);
      end
      chk("abort.no_done", 32'(stray), 32'd0);
      do_vec("after_abort", 8, 8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) rand_vec(8);
      for (int i = 0; i < 20; i++) rand_vec(5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
